mips_muldiv: RTL and testbench
==============================

# mips_muldiv

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in datapath width. It is the sequential companion to the combinational `mips_ALU` and executes MULT, MULTU, DIV and DIVU over multiple cycles. It also accepts MTHI/MTLO writes and presents HI/LO continuously for MFHI/MFLO. The core issues an operation with `start`, stalls on `busy`, and sees a one-cycle `done` pulse when the new HI/LO values are visible.

## Interface
- `WIDTH`, default 32: operand width and HI/LO width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launch an operation; sampled only when `busy`=0.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in WIDTH: rs operand (multiplicand / dividend).
- `b` in WIDTH: rt operand (multiplier / divisor).
- `hi_we` in 1: MTHI write strobe.
- `lo_we` in 1: MTLO write strobe.
- `hilo_wdata` in WIDTH: data for MTHI/MTLO.
- `busy` out 1: operation in flight; `start` is ignored while high.
- `done` out 1: one-cycle pulse; HI/LO hold the new result.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States:
  - IDLE: start → RUN; operands and op are latched.
  - RUN: counter 0..WIDTH-1; at count WIDTH-1 → FIX.
  - FIX: sign fixup, load HI/LO, → DONE.
  - DONE: `done`=1, → IDLE. `start` is accepted in DONE (acts as IDLE).
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at latch time; the core arithmetic is unsigned.
  - Product is negated if sign(a)≠sign(b).
  - Quotient is negated if sign(a)≠sign(b); remainder takes the sign of a.
- Multiply:
  - Shift-add, one multiplier bit per RUN cycle, into a 2·WIDTH accumulator.
  - HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divide:
  - Restoring, one quotient bit per RUN cycle.
  - LO = quotient, HI = remainder.
- Divide by zero (b=0) is defined, not trapped:
  - LO = all ones, HI = a (raw, unmodified).
  - Same latency as a normal divide.
- Signed overflow (a = −2^(WIDTH−1), b = −1): LO = 0x80..0, HI = 0. This is the natural truncation of the magnitude arithmetic.
- MTHI/MTLO:
  - `hi_we`/`lo_we` write `hilo_wdata` at the next edge, in any state.
  - If a write coincides with the FIX-state load, the operation result wins.
  - A completing operation overwrites both HI and LO, including values written during RUN.
- `rst`:
  - Forces IDLE and aborts any in-flight operation; no `done` is produced.
  - hi=0, lo=0, busy=0, done=0, counter=0.

## Timing
- Edge E0 samples `start`=1 with `busy`=0; `busy`=1 after E0.
- Edges E1..E(WIDTH) perform the RUN iterations.
- E(WIDTH+1) performs FIX and loads HI/LO.
- After E(WIDTH+1): `done`=1, `busy`=0, new `hi`/`lo` visible. Total latency is WIDTH+1 edges (33 for WIDTH=32).
- `done` falls after the next edge.
- Back-to-back: `start` held high during the `done` cycle launches the next operation at that edge.
- Operands `a`, `b` and `op` need only be valid in the E0 cycle.
- `hi`/`lo` are registered outputs and change only at edges.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle combinational WIDTH×WIDTH multiplier, bypassing RUN: IDLE → FIX → DONE.
  - HI/LO are loaded at E1, and `done`=1 after E1 (latency 1 edge).
  - Divide is unchanged.
- Undefined: all ops are iterative with WIDTH+1 latency. No multiplier array is inferred.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` after E33; `busy` high for exactly 33 cycles.
- MULT −3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIVU 7/2 → LO=3, HI=1. DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x1234/0 → LO=0xFFFFFFFF, HI=0x00001234. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Hazards:
  - During RUN of MULTU 6×7, pulse `hi_we` with 0xDEAD → `hi`=0xDEAD until E33, then HI=0, LO=42.
  - A second `start` mid-RUN is ignored and produces no extra `done`.
- Assert `rst` at the cycle after E10 of a DIVU → next cycle busy=0, hi=lo=0; no `done` within 40 cycles. A new DIVU 100/7 then gives LO=14, HI=2.
- With `MULDIV_FAST_MUL_EN`: MULTU 6×7 → `done` after E1, HI=0, LO=42. DIVU 100/7 is still 33 edges.

Source files
------------

// File: rtl/mips_muldiv_if.sv
// Core <-> multiply/divide unit bundle: operation launch, MTHI/MTLO writes,
// HI/LO readback and busy/done status.
interface mips_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hilo_wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, hilo_wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, hilo_wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO; MULDIV_FAST_MUL_EN selects a one-edge multiplier.
// Latency WIDTH+1 edges (multiply 1 edge with MULDIV_FAST_MUL_EN), done pulses for one cycle.
// No backpressure: start is ignored while busy, the core is expected to stall on busy.
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  mips_muldiv_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               launch;
  logic               last_iter;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div0;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   a_raw;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Signed ops are reduced to magnitudes at launch; the core loop is unsigned.
  logic             sgn_op;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    sgn_op = ~bus.op[0];
    sa     = sgn_op & bus.a[WIDTH-1];
    sb     = sgn_op & bus.b[WIDTH-1];
    mag_a  = sa ? -bus.a : bus.a;
    mag_b  = sb ? -bus.b : bus.b;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    last_iter = (cnt == CW'(WIDTH - 1));
    unique case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          launch = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
          state_nxt = bus.op[1] ? S_RUN : S_FIX;
`else
          state_nxt = S_RUN;
`endif
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN:   if (last_iter) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy = (state == S_RUN) || (state == S_FIX);
  assign bus.done = (state == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // acc = {partial, operand}: multiply shifts right adding m, divide shifts left subtracting m.
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     sub_diff;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    addend   = acc[0] ? m : {WIDTH{1'b0}};
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    sub_diff = rem_sh - {1'b0, m};
    if (is_div) begin
      if (sub_diff[WIDTH])
        acc_step = {acc[2*WIDTH-2:0], 1'b0};
      else
        acc_step = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {add_sum, acc[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (div0) begin
      // Division by zero returns the raw dividend rather than the loop's signed remainder.
      res_hi = a_raw;
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = rmd;
      res_lo = quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      m      <= '0;
      a_raw  <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        cnt    <= '0;
        is_div <= bus.op[1];
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        div0   <= (bus.b == '0);
        a_raw  <= bus.a;
        if (bus.op[1]) begin
          m   <= mag_b;
          acc <= {{WIDTH{1'b0}}, mag_a};
        end else begin
          m   <= mag_a;
`ifdef MULDIV_FAST_MUL_EN
          acc <= fast_prod;
`else
          acc <= {{WIDTH{1'b0}}, mag_b};
`endif
        end
      end else if (state == S_RUN) begin
        cnt <= cnt + 1'b1;
        acc <= acc_step;
      end

      // A completing operation takes priority over a coincident MTHI/MTLO.
      if (state == S_FIX) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else begin
        if (bus.hi_we) hi_q <= bus.hilo_wdata;
        if (bus.lo_we) lo_q <= bus.hilo_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: directed and random ops against a plain-arithmetic HI/LO model.
module tb_mips_muldiv;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mips_muldiv_if #(.WIDTH(32)) bus();

  mips_muldiv #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    longint      sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin
        p  = 64'(sx * sy);
        eh = p[63:32];
        el = p[31:0];
      end
      2'b01: begin
        p  = {32'd0, x} * {32'd0, y};
        eh = p[63:32];
        el = p[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = x;
        end else if (o == 2'b10) begin
          q  = sx / sy;
          r  = sx % sy;
          el = q[31:0];
          eh = r[31:0];
        end else begin
          el = x / y;
          eh = x % y;
        end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
    return o[1] ? 33 : 1;
`else
    return 33;
`endif
  endfunction

  // Called at a negedge; returns half a cycle after the launch edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_done(input int n0, output int n, output int nb);
    n  = n0;
    nb = 0;
    while (!bus.done && n < 200) begin
      if (bus.busy) nb++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    int n, nb, lat;
    model(o, x, y, eh, el);
    lat = exp_lat(o);
    issue(o, x, y);
    wait_done(0, n, nb);
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    chk({tag, ".busy_cycles"}, 32'(nb), 32'(lat));
    chk({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, ".hi"}, bus.hi, eh);
    chk({tag, ".lo"}, bus.lo, el);
    @(negedge clk);
    chk({tag, ".done_fall"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [31:0] eh, el, eh2, el2;
    logic [1:0]  ho, ro;
    logic [31:0] ha, hb, ra, rb;
    int n, nb, lat, pulses;

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.op         = 2'b00;
    bus.a          = '0;
    bus.b          = '0;
    bus.hi_we      = 1'b0;
    bus.lo_we      = 1'b0;
    bus.hilo_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.hi", bus.hi, 32'd0);
    chk("rst.lo", bus.lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5);
    run_op("divu_7_2", 2'b11, 32'd7, 32'd2);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("div_by0", 2'b10, 32'h0000_1234, 32'd0);
    run_op("div_by0_neg", 2'b10, 32'h8000_0001, 32'd0);
    run_op("divu_by0", 2'b11, 32'hCAFE_F00D, 32'd0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("multu_6x7", 2'b01, 32'd6, 32'd7);
    run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000);
    run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7);

    // MTHI/MTLO while idle
    bus.hi_we = 1'b1; bus.hilo_wdata = 32'h1357_9BDF;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi.hi", bus.hi, 32'h1357_9BDF);
    chk("mthi.lo_kept", bus.lo, 32'd14);
    bus.lo_we = 1'b1; bus.hilo_wdata = 32'h2468_ACE0;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mtlo.lo", bus.lo, 32'h2468_ACE0);

    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case (i % 4)
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb);
    end

    // Writes during the operation are visible, then overwritten; a write on the load edge loses.
`ifdef MULDIV_FAST_MUL_EN
    ho = 2'b11; ha = 32'd100; hb = 32'd7;
`else
    ho = 2'b01; ha = 32'd6;   hb = 32'd7;
`endif
    model(ho, ha, hb, eh, el);
    lat = exp_lat(ho);
    issue(ho, ha, hb);
    repeat (5) @(negedge clk);
    bus.hi_we = 1'b1; bus.hilo_wdata = 32'h0000_DEAD;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("haz.hi_dead", bus.hi, 32'h0000_DEAD);
    chk("haz.busy", 32'(bus.busy), 32'd1);
    bus.lo_we = 1'b1; bus.hilo_wdata = 32'h0000_BEEF;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("haz.lo_beef", bus.lo, 32'h0000_BEEF);
    repeat (lat - 1 - 7) @(negedge clk);
    chk("haz.not_done_yet", 32'(bus.done), 32'd0);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.hilo_wdata = 32'h5555_5555;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    chk("haz.done", 32'(bus.done), 32'd1);
    chk("haz.hi", bus.hi, eh);
    chk("haz.lo", bus.lo, el);
    @(negedge clk);

    // Second start mid-run is ignored
    model(2'b11, 32'd100, 32'd7, eh, el);
    issue(2'b11, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(6, n, nb);
    chk("mid.lat", 32'(n), 32'd33);
    chk("mid.hi", bus.hi, eh);
    chk("mid.lo", bus.lo, el);
    count_done(40, pulses);
    chk("mid.no_extra_done", 32'(pulses), 32'd0);

    // Back-to-back launch from the done cycle
    model(2'b10, 32'hFFFF_FFF9, 32'd2, eh2, el2);
    issue(2'b11, 32'd7, 32'd2);
    wait_done(0, n, nb);
    chk("b2b.first_lo", bus.lo, 32'd3);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("b2b.relaunch_busy", 32'(bus.busy), 32'd1);
    chk("b2b.relaunch_done", 32'(bus.done), 32'd0);
    wait_done(0, n, nb);
    chk("b2b.lat", 32'(n), 32'd33);
    chk("b2b.hi", bus.hi, eh2);
    chk("b2b.lo", bus.lo, el2);
    @(negedge clk);

    // Reset aborts an in-flight divide
    issue(2'b11, 32'h0000_FFFF, 32'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.hi", bus.hi, 32'd0);
    chk("abort.lo", bus.lo, 32'd0);
    count_done(40, pulses);
    chk("abort.no_done", 32'(pulses), 32'd0);
    run_op("post_rst_divu", 2'b11, 32'd100, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
